// File: rtl/apu_sequencer_if.sv
// Song-memory fetch port, host write port and merged APU register-write bus.
// No latency of its own; plain wiring between the sequencer and its environment.
// Fetches handshake with mem_rd/mem_valid; host writes are never stalled.
interface apu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_data;
  logic              host_wr;
  logic [3:0]        host_addr;
  logic [7:0]        host_data;
  logic              reg_wr;
  logic [3:0]        reg_addr;
  logic [7:0]        reg_data;
  logic              reg_change;

  // sequencer side
  modport master (
    output mem_rd, mem_addr, reg_wr, reg_addr, reg_data, reg_change,
    input  mem_valid, mem_data, host_wr, host_addr, host_data
  );

  // song memory, host and channel side
  modport slave (
    input  mem_rd, mem_addr, reg_wr, reg_addr, reg_data, reg_change,
    output mem_valid, mem_data, host_wr, host_addr, host_data
  );
endinterface

// File: rtl/apu_sequencer.sv
// Byte-coded song player that issues tick-paced APU register writes, merged with host writes.
// Host writes appear on reg_wr one cycle after host_wr; song fetches take one idle cycle between reads.
// Host writes always win the register bus; a colliding sequencer write retries the next cycle.
module apu_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int LOOP_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            tick,
  output logic            busy,
  apu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_DATA,
    S_WRITE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LOOP_PC = ADDR_W'(LOOP_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        idx_q;
  logic [7:0]        val_q;
  logic [6:0]        wait_q;
  logic              mem_rd_q, dirty_q, host_pend_q, busy_q;
  logic              reg_wr_q, reg_change_q;
  logic [3:0]        reg_addr_q;
  logic [7:0]        reg_data_q;

  logic       fetching, handshake, seq_commit, batch_end;
  logic [1:0] opc;

  assign opc        = bus.mem_data[7:6];
  assign fetching   = (state_q == S_FETCH_OP) || (state_q == S_FETCH_DATA);
  // a valid byte only counts while our own read request is up
  assign handshake  = fetching && mem_rd_q && bus.mem_valid;
  // host owns the bus this cycle if it writes; reserved indices are skipped silently
  assign seq_commit = (state_q == S_WRITE) && (idx_q < 4'hC) && !bus.host_wr && !stop;
  // reg_change marks the end of a batch when the player parks in WAIT or DONE
  assign batch_end  = ((state_d == S_WAIT) && (state_q != S_WAIT)) ||
                      ((state_d == S_DONE) && (state_q != S_DONE));

  // next-state decode of the song stream; stop overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_FETCH_OP;
      S_FETCH_OP: begin
        if (handshake) begin
          unique case (opc)
            2'b00:   state_d = S_FETCH_DATA;
            2'b01:   state_d = S_WAIT;
            2'b10:   state_d = S_FETCH_OP;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_FETCH_DATA: if (handshake) state_d = S_WRITE;
      S_WRITE:      if ((idx_q >= 4'hC) || !bus.host_wr) state_d = S_FETCH_OP;
      S_WAIT:       if (tick && (wait_q == 7'd1)) state_d = S_FETCH_OP;
      default:      state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // state, program counter, fetch request and registered register-bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      idx_q        <= 4'h0;
      val_q        <= 8'h00;
      wait_q       <= 7'd0;
      mem_rd_q     <= 1'b0;
      dirty_q      <= 1'b0;
      host_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_change_q <= 1'b0;
      reg_addr_q   <= 4'h0;
      reg_data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      // request drops after each accepted byte, so every fetch starts one cycle later
      mem_rd_q <= fetching && !handshake && !stop;

      if (((state_q == S_IDLE) || (state_q == S_DONE)) && start && !stop) begin
        pc_q <= '0;
      end else if (handshake && !stop) begin
        if ((state_q == S_FETCH_OP) && (opc == 2'b10)) pc_q <= LOOP_PC;
        else                                            pc_q <= pc_q + ADDR_W'(1);
      end

      if (handshake && (state_q == S_FETCH_OP)) begin
        idx_q  <= bus.mem_data[3:0];
        wait_q <= (bus.mem_data[5:0] == 6'd0) ? 7'd64 : {1'b0, bus.mem_data[5:0]};
      end else if ((state_q == S_WAIT) && tick) begin
        wait_q <= wait_q - 7'd1;
      end

      if (handshake && (state_q == S_FETCH_DATA)) val_q <= bus.mem_data;

      reg_wr_q <= bus.host_wr || seq_commit;
      if (bus.host_wr) begin
        reg_addr_q <= bus.host_addr;
        reg_data_q <= bus.host_data;
      end else if (seq_commit) begin
        reg_addr_q <= idx_q;
        reg_data_q <= val_q;
      end

      host_pend_q  <= bus.host_wr;
      reg_change_q <= host_pend_q || (batch_end && dirty_q);

      if (stop || batch_end) dirty_q <= 1'b0;
      else if (seq_commit)   dirty_q <= 1'b1;
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = pc_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_data   = reg_data_q;
  assign bus.reg_change = reg_change_q;
  assign busy           = busy_q;

endmodule
